// File: rtl/multdiv_wb_pkg.sv
// Shared definitions for the multdiv writeback merge stage: exception codes,
// destination-field position and the buffered entry layout.
package multdiv_wb_pkg;

    localparam logic [4:0]  RSTATUS_REG   = 5'd30;
    localparam logic [31:0] MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE  = 32'd5;

    localparam int RD_MSB = 26;
    localparam int RD_LSB = 22;

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } md_entry_t;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/md_wb_fifo.sv
// Circular buffer of pending multdiv writebacks with per-entry kill by
// destination register and a registered mask of live destinations.
module md_wb_fifo
    import multdiv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  md_entry_t   push_entry_i,
    input  logic        pop_i,
    input  logic        kill_i,
    input  logic [4:0]  kill_rd_i,
    output md_entry_t   head_o,
    output logic        empty_o,
    output logic        full_o,
    output logic [31:0] live_mask_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    md_entry_t       entries_q [DEPTH];
    md_entry_t       entries_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mask_q, mask_d;
    logic [DEPTH-1:0] kill_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_kill
            assign kill_hit[gi] = kill_i && (entries_q[gi].rd == kill_rd_i);
        end
    endgenerate

    // Push is applied last so that a full-buffer push+pop reuses the freed slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (kill_hit[i]) begin
                entries_d[i].live = 1'b0;
            end
            if (pop_i && (head_q == PW'(i))) begin
                entries_d[i].live = 1'b0;
            end
            if (push_i && (tail_q == PW'(i))) begin
                entries_d[i] = push_entry_i;
            end
        end
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(push_i);
        count_d = count_q + CW'(push_i) - CW'(pop_i);
        mask_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_d[i].live) begin
                mask_d = mask_d | rd_onehot(entries_d[i].rd);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    assign head_o      = entries_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign live_mask_o = mask_q;

endmodule

// File: rtl/multdiv_wb_merge.sv
// Merges completed mult/div results into the register-file write port in
// cycles the main W stage leaves idle; main writes always take the port.
module multdiv_wb_merge #(
    parameter int          DEPTH         = 2,
    parameter logic [4:0]  RSTATUS_REG   = multdiv_wb_pkg::RSTATUS_REG,
    parameter logic [31:0] MULT_EXC_CODE = multdiv_wb_pkg::MULT_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE  = multdiv_wb_pkg::DIV_EXC_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        md_ready,
    input  logic [31:0] md_result,
    input  logic [31:0] md_instr,
    input  logic        md_mult_overflow,
    input  logic        md_div_error,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pend_mask,
    output logic        md_full,
    output logic        md_drop
);
    import multdiv_wb_pkg::*;

    logic      md_ready_q;
    logic      drop_q, drop_d;
    logic      capture, cap_valid, main_wr;
    logic      push, pop, fifo_empty, fifo_full;
    md_entry_t cap_entry, head;
    logic      unused_instr_bits;

    assign unused_instr_bits = ^{md_instr[31:RD_MSB+1], md_instr[RD_LSB-1:0]};

    assign capture = md_ready && !md_ready_q;
    assign main_wr = wb_we && (wb_rd != 5'd0);

    // A capture colliding with a same-cycle main write is older, so it lands dead.
    always_comb begin
        cap_entry = '0;
        if (md_mult_overflow) begin
            cap_entry.rd   = RSTATUS_REG;
            cap_entry.data = MULT_EXC_CODE;
        end else if (md_div_error) begin
            cap_entry.rd   = RSTATUS_REG;
            cap_entry.data = DIV_EXC_CODE;
        end else begin
            cap_entry.rd   = md_instr[RD_MSB:RD_LSB];
            cap_entry.data = md_result;
        end
        cap_entry.live = !(main_wr && (cap_entry.rd == wb_rd));
    end

    assign cap_valid = capture && (cap_entry.rd != 5'd0);
    assign pop       = !main_wr && !fifo_empty;
    assign push      = cap_valid && (!fifo_full || pop);
    assign drop_d    = drop_q || (cap_valid && fifo_full && !pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_ready_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            md_ready_q <= md_ready;
            drop_q     <= drop_d;
        end
    end

    md_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (cap_entry),
        .pop_i        (pop),
        .kill_i       (main_wr),
        .kill_rd_i    (wb_rd),
        .head_o       (head),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full),
        .live_mask_o  (pend_mask)
    );

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (main_wr) begin
            ctrl_writeEnable = wb_we;
            ctrl_writeReg    = wb_rd;
            data_writeReg    = wb_data;
        end else if (!fifo_empty && head.live) begin
            ctrl_writeEnable = 1'b1;
            ctrl_writeReg    = head.rd;
            data_writeReg    = head.data;
        end
    end

    assign md_full = fifo_full;
    assign md_drop = drop_q;

endmodule

// File: tb/tb_multdiv_wb_merge.sv
// Self-checking bench for multdiv_wb_merge: directed scenarios plus random
// traffic, all checked against a queue-based model of the writeback buffer.
module tb_multdiv_wb_merge;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        md_ready = 1'b0;
    logic [31:0] md_result = '0;
    logic [31:0] md_instr = '0;
    logic        md_mult_overflow = 1'b0;
    logic        md_div_error = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pend_mask;
    logic        md_full;
    logic        md_drop;

    always #5 clock = ~clock;

    multdiv_wb_merge #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .md_ready         (md_ready),
        .md_result        (md_result),
        .md_instr         (md_instr),
        .md_mult_overflow (md_mult_overflow),
        .md_div_error     (md_div_error),
        .wb_we            (wb_we),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pend_mask        (pend_mask),
        .md_full          (md_full),
        .md_drop          (md_drop)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: program-ordered list of pending writebacks.
    typedef struct {
        bit        live;
        bit [4:0]  rd;
        bit [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    bit          m_prev = 1'b0;
    bit          m_drop = 1'b0;
    logic [71:0] exp_vec;

    function automatic logic [71:0] obs();
        return {ctrl_writeEnable, ctrl_writeReg, data_writeReg, pend_mask, md_full, md_drop};
    endfunction

    task automatic predict();
        bit          main;
        logic [31:0] pm;
        logic [37:0] port;
        main = wb_we && (wb_rd != 0);
        pm = '0;
        foreach (mq[i]) if (mq[i].live) pm[mq[i].rd] = 1'b1;
        if (main) port = {1'b1, wb_rd, wb_data};
        else if (mq.size() > 0 && mq[0].live) port = {1'b1, mq[0].rd, mq[0].data};
        else port = '0;
        exp_vec = {port, pm, (mq.size() == DEPTH), m_drop};
    endtask

    task automatic model_update();
        bit     main, cap, pop;
        int     sz;
        m_ent_t e;
        if (!reset) begin
            mq.delete();
            m_prev = 1'b0;
            m_drop = 1'b0;
            return;
        end
        main = wb_we && (wb_rd != 0);
        cap = md_ready && !m_prev;
        m_prev = md_ready;
        if (md_mult_overflow) e = '{1'b1, 5'd30, 32'd4};
        else if (md_div_error) e = '{1'b1, 5'd30, 32'd5};
        else e = '{1'b1, md_instr[26:22], md_result};
        sz = mq.size();
        pop = !main && (sz > 0);
        if (main) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 1'b0;
        if (pop) void'(mq.pop_front());
        if (cap && e.rd != 0) begin
            if (sz < DEPTH || pop) begin
                e.live = !(main && e.rd == wb_rd);
                mq.push_back(e);
            end else begin
                m_drop = 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clock);
        predict();
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_md(input logic r, input logic [4:0] rd, input logic [31:0] res,
                          input logic ovf, input logic de);
        md_ready = r;
        md_instr = {5'b10101, rd, 22'h15A5A};
        md_result = res;
        md_mult_overflow = ovf;
        md_div_error = de;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_we = we;
        wb_rd = rd;
        wb_data = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        compared++;
        if (obs() !== 72'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 0", obs());
        end
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_basic();
        set_md(1'b1, 5'd5, 32'h19, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL basic_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            compared++;
            if (i == 1 && ({ctrl_writeEnable, ctrl_writeReg, data_writeReg, pend_mask} !==
                           {1'b1, 5'd5, 32'h19, 32'h20})) begin
                mismatched++;
                $display("FAIL basic_write: got we=%0b rd=%0d d=%h pm=%h expected we=1 rd=5 d=19 pm=20",
                         ctrl_writeEnable, ctrl_writeReg, data_writeReg, pend_mask);
            end else if (i != 1 && (ctrl_writeEnable !== 1'b0 || pend_mask !== 32'd0)) begin
                mismatched++;
                $display("FAIL basic_idle c%0d: got we=%0b pm=%h expected we=0 pm=0",
                         i, ctrl_writeEnable, pend_mask);
            end
            advance();
            md_ready = 1'b0;
        end
    endtask

    task automatic test_exceptions();
        logic [31:0] codes [2];
        codes[0] = 32'd5;
        codes[1] = 32'd4;
        for (int k = 0; k < 2; k++) begin
            set_md(1'b1, 5'd12, 32'hBAD0BAD0, (k == 1), 1'b1);
            settle();
            advance();
            md_ready = 1'b0;
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL exc_model k%0d: got %h expected %h", k, obs(), exp_vec);
            end
            compared++;
            if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd30, codes[k]}) begin
                mismatched++;
                $display("FAIL exc_write k%0d: got we=%0b rd=%0d d=%h expected we=1 rd=30 d=%h",
                         k, ctrl_writeEnable, ctrl_writeReg, data_writeReg, codes[k]);
            end
            advance();
        end
    endtask

    task automatic test_main_priority();
        logic [4:0] exp_rd [4];
        exp_rd[0] = 5'd7; exp_rd[1] = 5'd8; exp_rd[2] = 5'd9; exp_rd[3] = 5'd3;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_md(1'b1, 5'd3, 32'hDEAD0003, 1'b0, 1'b0);
            else md_ready = 1'b0;
            if (i < 3) set_wb(1'b1, 5'(7 + i), 32'h100 + 32'(i));
            else set_wb(1'b0, 5'd0, 32'd0);
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL prio_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i < 4) begin
                compared++;
                if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== exp_rd[i]) begin
                    mismatched++;
                    $display("FAIL prio_order c%0d: got we=%0b rd=%0d expected we=1 rd=%0d",
                             i, ctrl_writeEnable, ctrl_writeReg, exp_rd[i]);
                end
            end
            advance();
        end
    endtask

    task automatic test_kill();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                set_md(1'b1, 5'd6, 32'h66, 1'b0, 1'b0);
                set_wb(1'b1, 5'd1, 32'h11);
            end else if (i == 1) begin
                md_ready = 1'b0;
                set_wb(1'b1, 5'd6, 32'hAA);
            end else begin
                set_wb(1'b0, 5'd0, 32'd0);
            end
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL kill_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            compared++;
            if (i == 1 && (pend_mask !== 32'h40 || data_writeReg !== 32'hAA)) begin
                mismatched++;
                $display("FAIL kill_main: got pm=%h d=%h expected pm=40 d=aa", pend_mask, data_writeReg);
            end else if (i >= 2 && (ctrl_writeEnable !== 1'b0 || pend_mask !== 32'd0)) begin
                mismatched++;
                $display("FAIL kill_dead c%0d: got we=%0b pm=%h expected we=0 pm=0",
                         i, ctrl_writeEnable, pend_mask);
            end
            advance();
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res [3];
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                res[i/2] = $urandom;
                set_md(1'b1, 5'(10 + i / 2), res[i/2], 1'b0, 1'b0);
            end else begin
                md_ready = 1'b0;
            end
            set_wb(1'b1, 5'(20 + i), $urandom);
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL ovf_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (i == 3 || i == 5) begin
                compared++;
                if (md_full !== 1'b1 || md_drop !== (i == 5)) begin
                    mismatched++;
                    $display("FAIL ovf_flags c%0d: got full=%0b drop=%0b expected full=1 drop=%0b",
                             i, md_full, md_drop, (i == 5));
                end
            end
            advance();
        end
        set_wb(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL drain_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            compared++;
            if (i < 2 && ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'(10 + i), res[i]})) begin
                mismatched++;
                $display("FAIL drain_order c%0d: got we=%0b rd=%0d d=%h expected we=1 rd=%0d d=%h",
                         i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, 10 + i, res[i]);
            end else if (i == 2 && (ctrl_writeEnable !== 1'b0 || md_drop !== 1'b1)) begin
                mismatched++;
                $display("FAIL drain_end: got we=%0b drop=%0b expected we=0 drop=1",
                         ctrl_writeEnable, md_drop);
            end
            advance();
        end
    endtask

    task automatic test_held_ready();
        int writes = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_md(1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
            else md_ready = 1'b0;
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL held_model c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            if (ctrl_writeEnable === 1'b1 && ctrl_writeReg === 5'd9) writes++;
            advance();
        end
        compared++;
        if (writes != 1) begin
            mismatched++;
            $display("FAIL held_once: got %0d writes expected 1", writes);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            if (i % 2 == 0) set_md(1'b1, 5'(13 + i / 2), $urandom, 1'b0, 1'b0);
            else md_ready = 1'b0;
            set_wb(1'b1, 5'(21 + i), $urandom);
            settle();
            advance();
        end
        md_ready = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        compared++;
        if (pend_mask !== 32'h6000) begin
            mismatched++;
            $display("FAIL rstmid_pre: got pm=%h expected pm=6000", pend_mask);
        end
        #2 reset = 1'b0;
        model_update();
        #1;
        compared++;
        if (obs() !== 72'd0) begin
            mismatched++;
            $display("FAIL rstmid_now: got %h expected 0", obs());
        end
        settle();
        advance();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            compared++;
            if (obs() !== exp_vec || ctrl_writeEnable !== 1'b0) begin
                mismatched++;
                $display("FAIL rstmid_after c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            md_ready = ($urandom_range(0, 2) == 0);
            md_instr = $urandom;
            md_instr[26:22] = 5'($urandom_range(0, 7));
            md_result = $urandom;
            md_mult_overflow = ($urandom_range(0, 9) == 0);
            md_div_error = ($urandom_range(0, 9) == 0);
            wb_we = ($urandom_range(0, 1) == 1);
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            settle();
            compared++;
            if (obs() !== exp_vec) begin
                mismatched++;
                $display("FAIL random c%0d: got %h expected %h", i, obs(), exp_vec);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exceptions();
        test_main_priority();
        test_kill();
        test_overflow();
        test_held_ready();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multdiv_wb_merge.md
# multdiv_wb_merge

Writeback merge stage directly downstream of the multdiv stage. Captures each completed mult/div result, or its exception, into a small ordered buffer, then drains it into the single register-file write port whenever the main pipeline's W stage is not writing. Main-pipeline writes always win the port. It also kills buffered results that a younger instruction overwrites, and publishes a pending-register mask for hazard logic.

## Interface
- DEPTH, 2: buffer entries; legal values are 2 or 4.
- RSTATUS_REG, 30: destination register for exception codes.
- MULT_EXC_CODE, 4: rstatus value on mult overflow.
- DIV_EXC_CODE, 5: rstatus value on divide error.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- md_ready  in  1  multdiv result-ready; may be held high for several cycles.
- md_result  in  32  multdiv result.
- md_instr  in  32  instruction latched in the multdiv stage; rd = md_instr[26:22].
- md_mult_overflow  in  1  exception flag for the current result.
- md_div_error  in  1  exception flag for the current result.
- wb_we  in  1  main W-stage write enable.
- wb_rd  in  5  main W-stage destination register.
- wb_data  in  32  main W-stage write data.
- ctrl_writeEnable  out  1  register-file write enable.
- ctrl_writeReg  out  5  register-file write address.
- data_writeReg  out  32  register-file write data.
- pend_mask  out  32  bit r is set while a live buffered entry targets register r.
- md_full  out  1  buffer full; decode must not issue a new mult/div.
- md_drop  out  1  sticky; set when a capture was lost to overflow; cleared only by reset.

## Operation
- Capture fires on the rising edge of md_ready, detected with a registered copy of md_ready. A level held high captures only once.
- The captured entry is {rd, data}:
  - md_mult_overflow set: {RSTATUS_REG, MULT_EXC_CODE}.
  - md_div_error set: {RSTATUS_REG, DIV_EXC_CODE}.
  - Neither set: {md_instr[26:22], md_result}.
  - Both set: mult overflow takes priority.
- A capture whose rd is 0 is discarded and does not enqueue.
- Each buffer entry holds {live, rd[4:0], data[31:0]}. The buffer is a circular FIFO with head and tail pointers and a count.
- Port arbitration, evaluated combinationally each cycle:
  - "main" = wb_we && wb_rd != 0. When main is true, the outputs pass wb_we, wb_rd and wb_data through unchanged.
  - When main is false and the head entry is live, the outputs present the head entry and it pops at the clock edge.
  - When main is false and the head entry is dead, the outputs are 0 and the head pops with no write.
  - With an empty buffer and no main write, all outputs are 0.
- Kill rule: when main is true, every live entry with rd == wb_rd clears live at the edge.
- A capture in the same cycle with rd == wb_rd enqueues with live = 0. The multdiv result is older in program order, so the younger W-stage write prevails.
- pend_mask is the OR of onehot(rd) over live entries and is registered state. It does not include operations still in flight inside the multdiv unit.
- md_full = (count == DEPTH).
- Capture while full with a pop in the same cycle: the capture is accepted.
- Capture while full with no pop: the capture is dropped, md_drop sets, and the buffer contents are unchanged.

## Timing
- Reset values: all outputs 0, count 0, all live bits 0, md_drop 0, edge-detect register 0.
- Minimum latency: a capture at the rising edge of md_ready at cycle N can write at cycle N+1.
- Entries drain in FIFO order, at most one write per cycle.
- A dead head consumes one idle port cycle.
- Main writes are never stalled by this block.
- pend_mask and md_full update at the same edge as the enqueue, pop or kill that changes them.
- Reset asserted mid-drain discards the buffer; no partial write reaches the outputs after reset asserts.

## Structure
- Shared package multdiv_wb_pkg:
  - RSTATUS_REG, MULT_EXC_CODE, DIV_EXC_CODE.
  - The rd bit-slice positions.
  - The entry struct {live, rd, data}.
- Sub-module md_wb_fifo: parameterised DEPTH circular buffer with push, pop, per-entry kill-by-rd, and live-mask output.
- The top level contains the edge detect, entry formation, arbitration mux and md_drop.

## Test plan
- Mult r5 result 0x0000_0019 with main idle: one cycle after the md_ready edge, write r5 = 0x19; pend_mask bit 5 is set for exactly one cycle.
- Div with md_div_error set: write r30 = 5. With md_mult_overflow and md_div_error both set: write r30 = 4.
- Main writes r7, r8, r9 back-to-back while a div result for r3 is buffered: r7, r8 and r9 are written first; r3 is written in the first idle cycle.
- Buffered entry for r6, then main writes r6 = 0xAA: r6 ends at 0xAA; the dead entry pops with no write; pend_mask bit 6 clears at the kill edge.
- DEPTH=2, three captures while main writes every cycle: md_full asserts after two captures; the third capture sets md_drop; with main idle, exactly two writes follow in order.
- md_ready held high for 4 cycles: exactly one capture. reset driven low with two entries buffered: outputs go to 0 and pend_mask to 0 immediately; no write occurs after reset is released.
